// File: rtl/execute.sv
// execute: pipeline execute stage with a one-hot ALU, data SRAM request and forwarding to decode.
// Define EXE_DIV_EN to build the 32-cycle restoring divider; otherwise div_op is ignored.
module execute (
    input  logic         clk,
    input  logic         rst,
    input  logic         M_allowin,
    output logic         E_allowin,
    input  logic         DE_valid,
    input  logic [153:0] DE_BUS,
    output logic         EM_valid,
    output logic [73:0]  EM_BUS,
    output logic [37:0]  ED_for_BUS,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        res_from_mem;
        logic [2:0]  div_op;
    } de_bus_t;

    de_bus_t     bus_q, bus_d;
    logic        e_valid_q, e_valid_d;
    logic        e_ready_go;
    logic        div_wait;
    logic        e_stall;
    logic [31:0] alu_result, sra_result, result;
    logic [4:0]  shamt;
    logic [3:0]  em_mem, byte_we, half_we;
    logic        mem_req;

    always_comb begin
        bus_d     = (DE_valid && E_allowin) ? de_bus_t'(DE_BUS) : bus_q;
        e_valid_d = E_allowin ? DE_valid : e_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q     <= '0;
            e_valid_q <= 1'b0;
        end else begin
            bus_q     <= bus_d;
            e_valid_q <= e_valid_d;
        end
    end

    // sra kept in its own assignment so the signed shift is not turned logical by the OR chain
    always_comb begin
        shamt      = bus_q.src2[4:0];
        sra_result = $signed(bus_q.src1) >>> shamt;
        alu_result = ({32{bus_q.alu_op[0]}}  & (bus_q.src1 + bus_q.src2))
                   | ({32{bus_q.alu_op[1]}}  & (bus_q.src1 - bus_q.src2))
                   | ({32{bus_q.alu_op[2]}}  & {31'd0, $signed(bus_q.src1) < $signed(bus_q.src2)})
                   | ({32{bus_q.alu_op[3]}}  & {31'd0, bus_q.src1 < bus_q.src2})
                   | ({32{bus_q.alu_op[4]}}  & (bus_q.src1 & bus_q.src2))
                   | ({32{bus_q.alu_op[5]}}  & ~(bus_q.src1 | bus_q.src2))
                   | ({32{bus_q.alu_op[6]}}  & (bus_q.src1 | bus_q.src2))
                   | ({32{bus_q.alu_op[7]}}  & (bus_q.src1 ^ bus_q.src2))
                   | ({32{bus_q.alu_op[8]}}  & (bus_q.src1 << shamt))
                   | ({32{bus_q.alu_op[9]}}  & (bus_q.src1 >> shamt))
                   | ({32{bus_q.alu_op[10]}} & sra_result)
                   | ({32{bus_q.alu_op[11]}} & bus_q.src2);
    end

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [32:0] trial;
    logic [31:0] q_out, r_out, div_result;
    logic        start, sgn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        start   = e_valid_q && bus_q.div_op[2];
        state_d = (state_q == IDLE && start)          ? BUSY :
                  (state_q == BUSY && cnt_q == 5'd31) ? DONE :
                  (state_q == DONE && M_allowin)      ? IDLE : state_q;
        cnt_d   = (state_q == BUSY) ? cnt_q + 5'd1 : 5'd0;
    end

    always_comb begin
        e_ready_go = !bus_q.div_op[2] || state_q == DONE;
        div_wait   = bus_q.div_op[2] && state_q != DONE;
    end

    // quo_q starts as |dividend| and shifts out one bit per step while quotient bits shift in
    always_comb begin
        sgn   = !bus_q.div_op[0];
        trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};
        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        if (state_q == IDLE && start) begin
            rem_d = 32'd0;
            quo_d = (sgn && bus_q.src1[31]) ? -bus_q.src1 : bus_q.src1;
            dsr_d = (sgn && bus_q.src2[31]) ? -bus_q.src2 : bus_q.src2;
        end else if (state_q == BUSY) begin
            rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
            quo_d = {quo_q[30:0], !trial[32]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dsr_q <= 32'd0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
        end
    end

    // divide by zero bypasses the sign fixup and returns the raw dividend as remainder
    always_comb begin
        q_out      = (sgn && (bus_q.src1[31] ^ bus_q.src2[31])) ? -quo_q : quo_q;
        r_out      = (sgn && bus_q.src1[31]) ? -rem_q : rem_q;
        div_result = (bus_q.src2 == 32'd0) ? (bus_q.div_op[1] ? bus_q.src1 : 32'hFFFF_FFFF)
                                           : (bus_q.div_op[1] ? r_out : q_out);
        result     = bus_q.div_op[2] ? div_result : alu_result;
    end
`else
    logic unused_div_op;

    always_comb begin
        e_ready_go    = 1'b1;
        div_wait      = 1'b0;
        result        = alu_result;
        unused_div_op = ^bus_q.div_op;
    end
`endif

    always_comb begin
        mem_req         = e_valid_q && (bus_q.mem_we || bus_q.res_from_mem);
        data_sram_en    = mem_req && e_ready_go && M_allowin;
        data_sram_addr  = alu_result;
        byte_we         = 4'b0001 << alu_result[1:0];
        half_we         = 4'b0011 << {alu_result[1], 1'b0};
        data_sram_we    = !(data_sram_en && bus_q.mem_we) ? 4'b0000 :
                          (bus_q.mem_size == 2'b00)       ? byte_we :
                          (bus_q.mem_size == 2'b01)       ? half_we : 4'b1111;
        data_sram_wdata = (bus_q.mem_size == 2'b00) ? {4{bus_q.rkd_value[7:0]}} :
                          (bus_q.mem_size == 2'b01) ? {2{bus_q.rkd_value[15:0]}} : bus_q.rkd_value;
        em_mem          = bus_q.res_from_mem ? {bus_q.mem_size == 2'b10, bus_q.mem_unsigned,
                                                bus_q.mem_size == 2'b01, bus_q.mem_size == 2'b00} : 4'b0000;
        e_stall         = e_valid_q && (bus_q.res_from_mem || div_wait);
        E_allowin       = !e_valid_q || (e_ready_go && M_allowin);
        EM_valid        = e_valid_q && e_ready_go;
        EM_BUS          = {bus_q.pc, result, bus_q.gr_we, bus_q.dest, em_mem};
        ED_for_BUS      = {e_stall, bus_q.dest & {5{e_valid_q && bus_q.gr_we}}, result};
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed and randomized checks of the execute stage against a behavioural model.
// Expectations follow EXE_DIV_EN: with it defined divides take 34 cycles, otherwise they are plain ALU ops.
module tb_execute;
`ifdef EXE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         M_allowin;
    logic         E_allowin;
    logic         DE_valid;
    logic [153:0] DE_BUS;
    logic         EM_valid;
    logic [73:0]  EM_BUS;
    logic [37:0]  ED_for_BUS;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .rst(rst), .M_allowin(M_allowin), .E_allowin(E_allowin),
        .DE_valid(DE_valid), .DE_BUS(DE_BUS), .EM_valid(EM_valid), .EM_BUS(EM_BUS),
        .ED_for_BUS(ED_for_BUS), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [153:0] mk(input logic [31:0] pc, input logic [11:0] op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] rkd, input logic gw, input logic [4:0] dst,
                                        input logic mw, input logic [1:0] sz, input logic un,
                                        input logic rf, input logic [2:0] dop);
        return {pc, op, s1, s2, rkd, gw, dst, mw, sz, un, rf, dop};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = -1;
        for (int i = 0; i < 12; i++) if (op[i]) k = i;
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: return (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0);
            11: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] dop);
        int sa, sb;
        if (b == 32'd0) return dop[1] ? a : 32'hFFFF_FFFF;
        if (dop[0]) return dop[1] ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return dop[1] ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return dop[1] ? sa % sb : sa / sb;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction into an empty stage, follow it to the memory stage and check everything on the way.
    task automatic run_instr(input string tag, input logic [153:0] b, input int hold);
        logic [31:0] pc, s1, s2, rkd, res, addr, wd_exp;
        logic [11:0] op;
        logic        gw, mw, un, rf;
        logic [4:0]  dst;
        logic [1:0]  sz;
        logic [2:0]  dop;
        logic [3:0]  we_exp, mfl;
        logic [73:0] em_exp;
        logic [37:0] ed_exp;
        int          lat, lat_exp, nbytes, base;
        {pc, op, s1, s2, rkd, gw, dst, mw, sz, un, rf, dop} = b;
        addr    = ref_alu(op, s1, s2);
        res     = (DIV_EN && dop[2]) ? ref_div(s1, s2, dop) : addr;
        lat_exp = (DIV_EN && dop[2]) ? 33 : 0;
        nbytes  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base    = int'(addr[1:0]) & ~(nbytes - 1);
        we_exp  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (mw && i >= base && i < base + nbytes) we_exp[i] = 1'b1;
            wd_exp[8*i +: 8] = rkd[8*(i % nbytes) +: 8];
        end
        mfl    = rf ? {sz == 2'b10, un, sz == 2'b01, sz == 2'b00} : 4'b0000;
        em_exp = {pc, res, gw, dst, mfl};
        ed_exp = {rf, gw ? dst : 5'd0, res};
        @(negedge clk);
        DE_valid  = 1'b1;
        DE_BUS    = b;
        M_allowin = 1'b1;
        #1;
        chk({tag, "_allowin_pre"}, E_allowin, 1);
        @(negedge clk);
        DE_valid = 1'b0;
        DE_BUS   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        lat = 0;
        while (!EM_valid && lat < 60) begin
            chk({tag, "_wait_allowin"}, E_allowin, 0);
            chk({tag, "_wait_stall"}, ED_for_BUS[37], 1);
            chk({tag, "_wait_en"}, data_sram_en, 0);
            @(negedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, lat_exp);
        if (hold > 0) begin
            M_allowin = 1'b0;
            #1;
            repeat (hold) begin
                chk({tag, "_hold_valid"}, EM_valid, 1);
                chk({tag, "_hold_em"}, EM_BUS, em_exp);
                chk({tag, "_hold_ed"}, ED_for_BUS, ed_exp);
                chk({tag, "_hold_en"}, data_sram_en, 0);
                chk({tag, "_hold_allowin"}, E_allowin, 0);
                @(negedge clk);
                #1;
            end
            M_allowin = 1'b1;
            #1;
        end
        chk({tag, "_em"}, EM_BUS, em_exp);
        chk({tag, "_ed"}, ED_for_BUS, ed_exp);
        chk({tag, "_allowin"}, E_allowin, 1);
        chk({tag, "_en"}, data_sram_en, mw | rf);
        chk({tag, "_we"}, data_sram_we, we_exp);
        if (mw | rf) chk({tag, "_addr"}, data_sram_addr, addr);
        if (mw) chk({tag, "_wdata"}, data_sram_wdata, wd_exp);
        @(negedge clk);
        #1;
        chk({tag, "_after_valid"}, EM_valid, 0);
        chk({tag, "_after_en"}, data_sram_en, 0);
        chk({tag, "_after_allowin"}, E_allowin, 1);
        chk({tag, "_after_fwd"}, ED_for_BUS[37:32], 6'd0);
    endtask

    initial begin
        logic [153:0] b;
        logic [11:0]  op;
        int           kind;
        rst       = 1'b1;
        M_allowin = 1'b1;
        DE_valid  = 1'b0;
        DE_BUS    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_allowin", E_allowin, 1);
        chk("rst_emvalid", EM_valid, 0);
        chk("rst_en", data_sram_en, 0);
        chk("rst_we", data_sram_we, 0);
        chk("rst_ed", ED_for_BUS, 0);
        chk("rst_em", EM_BUS, 0);

        run_instr("add", mk(32'h1c00_0000, 12'h001, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000), 0);
        run_instr("stb", mk(32'h1c00_0004, 12'h001, 32'h1000, 32'd3, 32'hAB, 1'b0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000), 0);
        run_instr("sth", mk(32'h1c00_0008, 12'h001, 32'h2001, 32'd2, 32'h1234_5678, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 3'b000), 0);
        run_instr("stw", mk(32'h1c00_000c, 12'h001, 32'h3000, 32'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 2'b10, 1'b0, 1'b0, 3'b000), 0);
        run_instr("ld_stall", mk(32'h1c00_0010, 12'h001, 32'h4000, 32'd4, 32'd0, 1'b1, 5'd9, 1'b0, 2'b01, 1'b1, 1'b1, 3'b000), 3);
        run_instr("divq", mk(32'h1c00_0014, 12'h001, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 5'd4, 1'b0, 2'b00, 1'b0, 1'b0, 3'b100), 0);
        run_instr("divr", mk(32'h1c00_0018, 12'h001, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 5'd5, 1'b0, 2'b00, 1'b0, 1'b0, 3'b110), 0);
        run_instr("divz_q", mk(32'h1c00_001c, 12'h002, 32'd10, 32'd0, 32'd0, 1'b1, 5'd6, 1'b0, 2'b00, 1'b0, 1'b0, 3'b101), 0);
        run_instr("divz_r", mk(32'h1c00_0020, 12'h002, 32'd10, 32'd0, 32'd0, 1'b1, 5'd7, 1'b0, 2'b00, 1'b0, 1'b0, 3'b111), 2);
        run_instr("divovf", mk(32'h1c00_0024, 12'h010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd8, 1'b0, 2'b00, 1'b0, 1'b0, 3'b100), 0);

        // reset while the divider is busy, then make sure the stage is clean and fully usable
        @(negedge clk);
        DE_valid = 1'b1;
        DE_BUS   = mk(32'h1c00_0028, 12'h001, 32'd100, 32'd7, 32'd0, 1'b1, 5'd2, 1'b0, 2'b00, 1'b0, 1'b0, 3'b100);
        @(negedge clk);
        DE_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_emvalid", EM_valid, 0);
        chk("abort_allowin", E_allowin, 1);
        chk("abort_ed", ED_for_BUS, 0);
        chk("abort_em", EM_BUS, 0);
        run_instr("post_abort_add", mk(32'h1c00_002c, 12'h001, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000), 0);
        run_instr("post_abort_div", mk(32'h1c00_0030, 12'h001, 32'd100, 32'd7, 32'd0, 1'b1, 5'd2, 1'b0, 2'b00, 1'b0, 1'b0, 3'b101), 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            op   = ($urandom_range(0, 12) == 12) ? 12'd0 : (12'd1 << $urandom_range(0, 11));
            if (kind < 3)
                b = mk($urandom, op, rv(), rv(), $urandom, 1'($urandom), 5'($urandom), 1'b0, 2'b00, 1'b0, 1'b0,
                       {1'b1, 2'($urandom)});
            else if (kind < 5)
                b = mk($urandom, 12'h001, $urandom, 32'($urandom_range(0, 15)), $urandom, 1'b1, 5'($urandom), 1'b0,
                       2'($urandom_range(0, 2)), 1'($urandom), 1'b1, 3'b000);
            else if (kind < 7)
                b = mk($urandom, 12'h001, $urandom, 32'($urandom_range(0, 15)), $urandom, 1'b0, 5'($urandom), 1'b1,
                       2'($urandom_range(0, 2)), 1'b0, 1'b0, 3'b000);
            else
                b = mk($urandom, op, rv(), rv(), $urandom, 1'($urandom), 5'($urandom), 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
            run_instr($sformatf("rnd%0d", n), b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
